// File: rtl/pl_bram_rd_pkg.sv
// Shared types and width helpers for the PL BRAM read sequencer.
// Word size and alignment are derived from the data width of the instantiating block.
package pl_bram_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int byte_off_bits(input int data_width);
        return $clog2(bytes_per_word(data_width));
    endfunction

    // Low address bits that must be zero for a word-aligned byte address.
    function automatic int align_mask(input int data_width);
        return (1 << byte_off_bits(data_width)) - 1;
    endfunction

endpackage

// File: rtl/pl_bram_rd_fifo.sv
// Synchronous FIFO with occupancy count and a zeroed read port when empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module pl_bram_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && (count_q != CNT_W'(DEPTH));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides validity, so the array maps to plain RAM.
    always_ff @(posedge ACLK) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/pl_bram_rd_seq.sv
// Walks a BRAM read port over [base_addr, base_addr + len words) and streams the data out.
// Reads are issued only when buffer space is reserved for them, so nothing is lost to read latency.
module pl_bram_rd_seq
    import pl_bram_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    bram_en,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    input  logic [DATA_WIDTH-1:0]   bram_rddata,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast
);

    localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
    localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W          = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(align_mask(DATA_WIDTH));

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   issued_q, issued_d;
    logic [LEN_WIDTH-1:0]   out_cnt_q, out_cnt_d;
    logic [LEN_WIDTH-1:0]   out_total_q, out_total_d;
    logic                   err_q, err_d;
    logic [RD_LAT-1:0]      infl_q, infl_d;

    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       infl_cnt;
    logic                   credit_ok;
    logic                   final_word;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   bad_cmd;
    logic                   drain_empty;

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            infl_cnt = infl_cnt + CNT_W'(infl_q[i]);
        end
    end

    // Issue rule: every outstanding read already owns a FIFO slot.
    always_comb begin
        push        = infl_q[RD_LAT-1];
        pop         = !fifo_empty && m_tready;
        credit_ok   = (SUM_W'(fifo_count) + SUM_W'(infl_cnt)) < SUM_W'(FIFO_DEPTH);
        final_word  = (issued_q + LEN_WIDTH'(1)) == len_q;
        issue       = (state_q == ST_RUN) && (issued_q != len_q) && credit_ok
                      && (!abort || final_word);
        bad_cmd     = (len == '0) || ((base_addr & ALIGN_MASK) != '0);
        drain_empty = (infl_cnt == '0)
                      && ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        issued_d    = issued_q;
        out_cnt_d   = out_cnt_q;
        out_total_d = out_total_q;
        err_d       = err_q;
        infl_d      = (infl_q << 1) | RD_LAT'(issue);

        if (pop) out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
        if (issue) begin
            addr_d   = addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
            issued_d = issued_q + LEN_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    len_d       = len;
                    issued_d    = '0;
                    out_cnt_d   = '0;
                    out_total_d = len;
                    err_d       = bad_cmd;
                    // A rejected command still spends one busy cycle before its done pulse.
                    state_d     = bad_cmd ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && final_word) begin
                    state_d = ST_DRAIN;
                end else if (abort) begin
                    state_d     = ST_DRAIN;
                    out_total_d = issued_q;
                end
            end
            ST_DRAIN: begin
                if (drain_empty) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            out_cnt_q   <= '0;
            out_total_q <= '0;
            err_q       <= 1'b0;
            infl_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            out_cnt_q   <= out_cnt_d;
            out_total_q <= out_total_d;
            err_q       <= err_d;
            infl_q      <= infl_d;
        end
    end

    pl_bram_rd_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .push   (push),
        .wdata  (bram_rddata),
        .pop    (pop),
        .rdata  (m_tdata),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // After an abort the target count shrinks to what was issued, so m_tlast follows the last real word.
    assign m_tvalid  = !fifo_empty;
    assign m_tlast   = !fifo_empty && (out_cnt_q == (out_total_q - LEN_WIDTH'(1)));
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign bram_en   = issue;
    assign bram_addr = addr_q;
    assign bram_we   = '0;

endmodule
